palette_index_encoder: RTL
==========================

// Module: palette_index_encoder
// PURPOSE
//  Reverse of the 16-entry background palette lookup: maps a 12-bit RGB pixel to the
//  nearest 4-bit palette index. Used by the sprite/background asset path to requantize
//  colours, and by debug capture to re-index frame-buffer pixels.
//  Performs a sequential nearest-colour search, one palette entry per clock.
//  Valid/ready handshake on both the input and the output side.
// PARAMETERS
//  EARLY_EXIT  1  1: stop the search at the first exact match (distance 0). 0: always scan all 16 entries.
// PORTS
//  Clk        in   1   system clock; all state changes on the rising edge
//  Reset      in   1   asynchronous, active-high reset
//  in_valid   in   1   rgb_in is valid
//  in_ready   out  1   encoder can accept a pixel
//  rgb_in     in   12  {red[3:0], green[3:0], blue[3:0]}
//  out_valid  out  1   result is valid
//  out_ready  in   1   consumer accepts the result
//  index_out  out  4   nearest palette index
//  dist_out   out  6   SAD distance of the winning entry (0..45)
//  exact_out  out  1   1 iff dist_out == 0
// BEHAVIOUR
//  Palette ROM (index:RGB hex), fixed:
//   0:AD6 1:8EF 2:DCC 3:AAA 4:FFF 5:BFF 6:E76 7:6EF 8:9C5 9:BE7 10:CBB 11:BD8 12:EED 13:CE8 14:D96 15:DEB
//  Distance = |dR|+|dG|+|dB| on the 4-bit channels, unsigned, 6-bit result. No weighting.
//  FSM states: IDLE, SEARCH, DONE.
//   IDLE:   in_ready=1. On in_valid&in_ready: latch rgb_in; set best_dist=63, best_idx=0, idx=0;
//           go to SEARCH.
//   SEARCH: each cycle, compute d for entry idx against the latched RGB.
//           If d < best_dist (strict): best<=d, best_idx<=idx. Ties keep the lower index.
//           Go to DONE if idx==15, or if EARLY_EXIT and d==0. Otherwise idx<=idx+1.
//           idx is 4 bits and never wraps.
//   DONE:   out_valid=1; index_out/dist_out/exact_out are held stable.
//           On out_ready, go to IDLE. While out_ready=0, hold indefinitely.
//  Latency, counted in rising edges after the accept edge:
//   - EARLY_EXIT=1, exact match at entry k: out_valid asserts after edge k+1.
//   - Otherwise: out_valid asserts after edge 16.
//  in_ready=0 in SEARCH and DONE. There is no overlap and no skid buffer.
//   Throughput is at most one pixel per (latency + 2) cycles.
//  The DONE->IDLE edge does not accept a new input; acceptance happens only from IDLE.
//  index_out/dist_out/exact_out may change only on the edge that enters DONE.
//   They keep their last value in IDLE and SEARCH.
//  rgb_in is sampled only on the accept edge; later changes on rgb_in are ignored.
//  Reset (any time, including mid-SEARCH or in DONE) immediately:
//   state=IDLE, out_valid=0, index_out=0, dist_out=0, exact_out=0, idx=0.
//   in_ready=0 while Reset is high, and 1 in the first cycle after release.
// TESTING
//  1. rgb_in=AD6, EARLY_EXIT=1 -> index 0, dist 0, exact 1; out_valid after edge 1.
//  2. rgb_in=000 -> index 8, dist 26, exact 0; out_valid after edge 16 (same for EARLY_EXIT=0).
//  3. Tie: rgb_in=BAB (entries 3 and 10 both at dist 2) -> index 3, dist 2.
//  4. rgb_in=FFF, out_ready held low 10 cycles -> out_valid and outputs stable, in_ready=0;
//     result handed off on the out_ready edge; in_ready=1 the next cycle.
//  5. EARLY_EXIT=0, rgb_in=AD6 -> index 0, dist 0; out_valid after edge 16
//     (later exact matches must not displace the lower index).
//  6. Assert Reset in cycle 5 of SEARCH -> all outputs at reset values, no out_valid;
//     the next accepted rgb_in=CE8 gives index 13, dist 0.

Source files
------------

// File: rtl/palette_index_encoder.sv
// palette_index_encoder
//   Maps a 12-bit RGB pixel to the nearest entry of the fixed 16-entry background
//   palette. The search is sequential and checks one palette entry per clock. The
//   distance metric is the plain sum of absolute differences over the three 4-bit
//   channels.
//
// Parameters
//   EARLY_EXIT  1: stop at the first exact match. 0: always scan all 16 entries.
//
// Ports
//   Clk        system clock (rising edge)
//   Reset      asynchronous, active-high reset
//   in_valid   rgb_in is valid
//   in_ready   encoder is idle and can accept a pixel
//   rgb_in     {red[3:0], green[3:0], blue[3:0]}
//   out_valid  a result is being presented
//   out_ready  consumer takes the result
//   index_out  nearest palette index
//   dist_out   SAD distance of the winning entry (0..45)
//   exact_out  1 iff dist_out == 0
module palette_index_encoder #(
    parameter logic EARLY_EXIT = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] rgb_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  index_out,
    output logic [5:0]  dist_out,
    output logic        exact_out
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] rgb_q;
    logic [3:0]  idx;
    logic [5:0]  best_dist;
    logic [3:0]  best_idx;

    function automatic logic [11:0] palette(input logic [3:0] i);
        logic [11:0] c;
        case (i)
            4'd0:  c = 12'hAD6;
            4'd1:  c = 12'h8EF;
            4'd2:  c = 12'hDCC;
            4'd3:  c = 12'hAAA;
            4'd4:  c = 12'hFFF;
            4'd5:  c = 12'hBFF;
            4'd6:  c = 12'hE76;
            4'd7:  c = 12'h6EF;
            4'd8:  c = 12'h9C5;
            4'd9:  c = 12'hBE7;
            4'd10: c = 12'hCBB;
            4'd11: c = 12'hBD8;
            4'd12: c = 12'hEED;
            4'd13: c = 12'hCE8;
            4'd14: c = 12'hD96;
            default: c = 12'hDEB;
        endcase
        return c;
    endfunction

    function automatic logic [5:0] absd(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        r = (a >= b) ? (a - b) : (b - a);
        return {2'b00, r};
    endfunction

    // Distance of the entry currently under test.
    logic [11:0] entry;
    logic [5:0]  d;
    logic        take;
    logic [5:0]  cand_dist;
    logic [3:0]  cand_idx;
    logic        last;

    always_comb begin
        entry     = palette(idx);
        d         = absd(rgb_q[11:8], entry[11:8])
                  + absd(rgb_q[7:4],  entry[7:4])
                  + absd(rgb_q[3:0],  entry[3:0]);
        // Strict compare: on a tie the lower index already held wins.
        take      = (d < best_dist);
        cand_dist = take ? d   : best_dist;
        cand_idx  = take ? idx : best_idx;
        last      = (idx == 4'd15) || (EARLY_EXIT && (d == 6'd0));
    end

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                // Gated by Reset so nothing looks acceptable while reset is held.
                in_ready = !Reset;
                if (in_valid) state_nxt = SEARCH;
            end
            SEARCH: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Search datapath and result registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rgb_q     <= 12'h000;
            idx       <= 4'd0;
            best_dist <= 6'd63;
            best_idx  <= 4'd0;
            index_out <= 4'd0;
            dist_out  <= 6'd0;
            exact_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rgb_q     <= rgb_in;
                        idx       <= 4'd0;
                        best_dist <= 6'd63;
                        best_idx  <= 4'd0;
                    end
                end
                SEARCH: begin
                    best_dist <= cand_dist;
                    best_idx  <= cand_idx;
                    if (last) begin
                        // Results only ever change on the edge entering DONE.
                        index_out <= cand_idx;
                        dist_out  <= cand_dist;
                        exact_out <= (cand_dist == 6'd0);
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
